timer_preset_loader: RTL and testbench

TIMER_PRESET_LOADER -- requirements
Module: timer_preset_loader

---
 rtl/timer_pkg.sv | 21 ++
 rtl/edge_detect_rise.sv | 30 +++
 rtl/timer_preset_loader.sv | 122 ++++++++++++
 tb/tb_timer_preset_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: definitions shared by the timer preset loader and its bench.
//   state_e              - controller states
//   KEY_CANCEL           - keypad code that clears the preset
//   KEY_DIGIT_MAX        - highest keypad code that is a digit
//   SEC_TENS_MAX_DEFAULT - largest legal seconds-tens digit
package timer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] KEY_CANCEL    = 4'd10;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam int unsigned SEC_TENS_MAX_DEFAULT = 5;

endpackage

// File: rtl/edge_detect_rise.sv
// edge_detect_rise: one-cycle pulse on a rising edge of a level input.
//   clock  - system clock, rising edge
//   clear  - async active-low reset
//   d_i    - level input (already synchronous to clock)
//   rise_o - high for the one cycle in which d_i is high and was low before
module edge_detect_rise (
    input  logic clock,
    input  logic clear,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;
    logic armed_q;

    // armed_q stays low until the input has been seen low once after reset,
    // so a level held through reset never produces an edge when reset lifts.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= d_i;
            armed_q <= armed_q | ~d_i;
        end
    end

    assign rise_o = d_i & ~prev_q & armed_q;

endmodule

// File: rtl/timer_preset_loader.sv
// timer_preset_loader: keypad entry of an M:SS preset, load strobe to a
// BCD counter chain, and run/pause/done control of that chain.
//   clock, clear      - clock (rising edge), async active-low reset
//   key_valid/key_code- keypad level and code (0-9 digit, 10 cancel)
//   start             - start/pause button level
//   timer_zero        - counter chain reads 0:00
//   loadn             - active-low load strobe to the counters
//   data_min/_sec_*   - BCD preset presented to the counters
//   count_en          - count enable to the seconds-ones counter
//   done, err         - single-cycle status pulses
module timer_preset_loader
    import timer_pkg::*;
#(
    parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       timer_zero,
    output logic       loadn,
    output logic [3:0] data_min,
    output logic [3:0] data_sec_tens,
    output logic [3:0] data_sec_ones,
    output logic       count_en,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] TENS_MAX = 4'(SEC_TENS_MAX);

    state_e     state_q;
    logic [3:0] min_q, tens_q, ones_q;
    logic       loadn_q, done_q, err_q;
    logic       key_ev, start_ev;

    edge_detect_rise u_key_edge (
        .clock  (clock),
        .clear  (clear),
        .d_i    (key_valid),
        .rise_o (key_ev)
    );

    edge_detect_rise u_start_edge (
        .clock  (clock),
        .clear  (clear),
        .d_i    (start),
        .rise_o (start_ev)
    );

    logic is_digit, is_cancel, start_only, preset_bad;
    assign is_digit   = (key_code <= KEY_DIGIT_MAX);
    assign is_cancel  = (key_code == KEY_CANCEL);
    // A key event in the same cycle swallows the start event.
    assign start_only = start_ev & ~key_ev;
    assign preset_bad = (tens_q > TENS_MAX) ||
                        (min_q == 4'd0 && tens_q == 4'd0 && ones_q == 4'd0);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            loadn_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            loadn_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (key_ev && is_cancel && state_q != S_LOAD) begin
                min_q   <= 4'd0;
                tens_q  <= 4'd0;
                ones_q  <= 4'd0;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE, S_ENTRY: begin
                        if (key_ev && is_digit) begin
                            min_q   <= tens_q;
                            tens_q  <= ones_q;
                            ones_q  <= key_code;
                            state_q <= S_ENTRY;
                        end else if (start_only && state_q == S_ENTRY) begin
                            if (preset_bad) begin
                                err_q <= 1'b1;
                            end else begin
                                loadn_q <= 1'b0;
                                state_q <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: state_q <= S_RUN;
                    S_RUN: begin
                        // Zero wins over pause so the chain never wraps.
                        if (timer_zero) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (start_only) begin
                            state_q <= S_PAUSE;
                        end
                    end
                    S_PAUSE: if (start_only) state_q <= S_RUN;
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // count_en follows timer_zero combinationally and drops with reset.
    assign count_en      = (state_q == S_RUN) & ~timer_zero;
    assign loadn         = loadn_q;
    assign done          = done_q;
    assign err           = err_q;
    assign data_min      = min_q;
    assign data_sec_tens = tens_q;
    assign data_sec_ones = ones_q;

endmodule

// File: tb/tb_timer_preset_loader.sv
module tb_timer_preset_loader;
    import timer_pkg::*;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       start = 1'b0;
    logic       timer_zero = 1'b0;
    logic       loadn, count_en, done, err;
    logic [3:0] data_min, data_sec_tens, data_sec_ones;

    timer_preset_loader dut (
        .clock(clock), .clear(clear), .key_valid(key_valid), .key_code(key_code),
        .start(start), .timer_zero(timer_zero), .loadn(loadn),
        .data_min(data_min), .data_sec_tens(data_sec_tens), .data_sec_ones(data_sec_ones),
        .count_en(count_en), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int load_cycles = 0;
    logic [11:0] exp_q[$];
    logic [3:0] m_min = 0, m_tens = 0, m_ones = 0;

    // Scoreboard: every loadn-low cycle must match a preset queued at start.
    always @(negedge clock) begin
        if (loadn === 1'b0) begin
            load_cycles++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_load: loadn low with data %0h%0h%0h, none expected",
                         data_min, data_sec_tens, data_sec_ones);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({data_min, data_sec_tens, data_sec_ones} !== e)
                    $display("FAIL load_data: got %h want %h",
                             {data_min, data_sec_tens, data_sec_ones}, e);
                else passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic press_raw(input logic [3:0] k);
        key_code = k; key_valid = 1'b1; tick();
        key_valid = 1'b0; tick();
    endtask

    task automatic press_digit(input logic [3:0] k);
        press_raw(k);
        m_min = m_tens; m_tens = m_ones; m_ones = k;
    endtask

    task automatic cancel();
        press_raw(KEY_CANCEL);
        m_min = 0; m_tens = 0; m_ones = 0;
    endtask

    // Enter three digits, start, and confirm a one-cycle load into RUN.
    task automatic run_preset(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        int lc0;
        press_digit(a); press_digit(b); press_digit(c);
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== {m_min, m_tens, m_ones})
            $display("FAIL entry_digits: got %h want %h", {data_min, data_sec_tens, data_sec_ones}, {m_min, m_tens, m_ones});
            else passed++;
        exp_q.push_back({m_min, m_tens, m_ones});
        lc0 = load_cycles;
        start = 1'b1; tick();
        checks++; if (loadn !== 1'b0 || count_en !== 1'b0)
            $display("FAIL load_cycle: loadn=%b count_en=%b want 0 0", loadn, count_en); else passed++;
        start = 1'b0; tick();
        checks++; if (loadn !== 1'b1 || count_en !== 1'b1 || dut.state_q !== S_RUN)
            $display("FAIL run_entry: loadn=%b count_en=%b state=%0d want 1 1 %0d", loadn, count_en, dut.state_q, S_RUN);
            else passed++;
        checks++; if (load_cycles - lc0 !== 1)
            $display("FAIL load_len: got %0d cycles want 1", load_cycles - lc0); else passed++;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({loadn, count_en, done, err} !== 4'b1000 || dut.state_q !== S_IDLE)
            $display("FAIL reset_outputs: got %b state %0d want 1000 state 0", {loadn, count_en, done, err}, dut.state_q);
            else passed++;
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== 12'h000)
            $display("FAIL reset_digits: got %h want 000", {data_min, data_sec_tens, data_sec_ones}); else passed++;
        clear = 1'b1; tick(); tick();
    endtask

    task automatic test_start_idle();
        start = 1'b1; tick(); start = 1'b0; tick();
        checks++; if (dut.state_q !== S_IDLE || err !== 1'b0)
            $display("FAIL start_in_idle: state %0d err %b want %0d 0", dut.state_q, err, S_IDLE); else passed++;
    endtask

    task automatic test_load_and_done();
        run_preset(4'd1, 4'd3, 4'd0);
        timer_zero = 1'b1; #1;
        checks++; if (count_en !== 1'b0)
            $display("FAIL zero_same_cycle: count_en %b want 0", count_en); else passed++;
        tick();
        checks++; if (done !== 1'b1 || dut.state_q !== S_DONE)
            $display("FAIL done_pulse: done %b state %0d want 1 %0d", done, dut.state_q, S_DONE); else passed++;
        timer_zero = 1'b0; tick();
        checks++; if (done !== 1'b0 || dut.state_q !== S_IDLE)
            $display("FAIL after_done: done %b state %0d want 0 %0d", done, dut.state_q, S_IDLE); else passed++;
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== {m_min, m_tens, m_ones})
            $display("FAIL done_retain: got %h want %h", {data_min, data_sec_tens, data_sec_ones}, {m_min, m_tens, m_ones});
            else passed++;
    endtask

    task automatic test_shift();
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== 12'h234 || {m_min, m_tens, m_ones} !== 12'h234)
            $display("FAIL shift_four: got %h want 234", {data_min, data_sec_tens, data_sec_ones}); else passed++;
        press_raw(4'd12);
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== {m_min, m_tens, m_ones})
            $display("FAIL ignore_code12: got %h want %h", {data_min, data_sec_tens, data_sec_ones}, {m_min, m_tens, m_ones});
            else passed++;
        cancel();
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== 12'h000 || dut.state_q !== S_IDLE)
            $display("FAIL cancel_entry: got %h state %0d want 000 %0d", {data_min, data_sec_tens, data_sec_ones}, dut.state_q, S_IDLE);
            else passed++;
    endtask

    task automatic test_err();
        press_digit(4'd1); press_digit(4'd7); press_digit(4'd0);
        start = 1'b1; tick();
        checks++; if (err !== 1'b1 || loadn !== 1'b1 || dut.state_q !== S_ENTRY)
            $display("FAIL err_tens: err %b loadn %b state %0d want 1 1 %0d", err, loadn, dut.state_q, S_ENTRY); else passed++;
        start = 1'b0; tick();
        checks++; if (err !== 1'b0 || dut.state_q !== S_ENTRY)
            $display("FAIL err_single: err %b state %0d want 0 %0d", err, dut.state_q, S_ENTRY); else passed++;
        cancel();
        press_digit(4'd0); press_digit(4'd0); press_digit(4'd0);
        start = 1'b1; tick();
        checks++; if (err !== 1'b1 || dut.state_q !== S_ENTRY)
            $display("FAIL err_zero: err %b state %0d want 1 %0d", err, dut.state_q, S_ENTRY); else passed++;
        start = 1'b0; tick();
        cancel();
    endtask

    task automatic test_pause();
        run_preset(4'd0, 4'd4, 4'd5);
        start = 1'b1; tick(); start = 1'b0; tick();
        checks++; if (count_en !== 1'b0 || dut.state_q !== S_PAUSE)
            $display("FAIL pause: count_en %b state %0d want 0 %0d", count_en, dut.state_q, S_PAUSE); else passed++;
        start = 1'b1; tick(); start = 1'b0; tick();
        checks++; if (count_en !== 1'b1 || dut.state_q !== S_RUN)
            $display("FAIL resume: count_en %b state %0d want 1 %0d", count_en, dut.state_q, S_RUN); else passed++;
        // Key and start together: key wins, start dropped, digit ignored in RUN.
        key_code = 4'd6; key_valid = 1'b1; start = 1'b1; tick();
        key_valid = 1'b0; start = 1'b0; tick();
        checks++; if (dut.state_q !== S_RUN || {data_min, data_sec_tens, data_sec_ones} !== {m_min, m_tens, m_ones})
            $display("FAIL key_priority: state %0d data %h want %0d %h", dut.state_q,
                     {data_min, data_sec_tens, data_sec_ones}, S_RUN, {m_min, m_tens, m_ones}); else passed++;
        start = 1'b1; tick(); start = 1'b0; tick();
        cancel();
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== 12'h000 || dut.state_q !== S_IDLE || count_en !== 1'b0)
            $display("FAIL cancel_pause: data %h state %0d count_en %b want 000 %0d 0",
                     {data_min, data_sec_tens, data_sec_ones}, dut.state_q, count_en, S_IDLE); else passed++;
    endtask

    task automatic test_zero_and_start();
        run_preset(4'd2, 4'd0, 4'd1);
        timer_zero = 1'b1; start = 1'b1; tick();
        checks++; if (dut.state_q !== S_DONE || done !== 1'b1)
            $display("FAIL zero_beats_start: state %0d done %b want %0d 1", dut.state_q, done, S_DONE); else passed++;
        timer_zero = 1'b0; start = 1'b0; tick(); tick();
    endtask

    task automatic test_reset_mid_run();
        cancel();
        run_preset(4'd0, 4'd1, 4'd5);
        key_code = 4'd7; key_valid = 1'b1;
        #2 clear = 1'b0; #1;
        checks++; if (count_en !== 1'b0 || dut.state_q !== S_IDLE)
            $display("FAIL async_reset: count_en %b state %0d want 0 %0d", count_en, dut.state_q, S_IDLE); else passed++;
        m_min = 0; m_tens = 0; m_ones = 0;
        tick(); tick(); clear = 1'b1; tick(); tick(); tick();
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== 12'h000 || dut.state_q !== S_IDLE)
            $display("FAIL held_key_after_reset: data %h state %0d want 000 %0d",
                     {data_min, data_sec_tens, data_sec_ones}, dut.state_q, S_IDLE); else passed++;
        key_valid = 1'b0; tick();
        press_digit(4'd8);
        checks++; if ({data_min, data_sec_tens, data_sec_ones} !== {m_min, m_tens, m_ones} || dut.state_q !== S_ENTRY)
            $display("FAIL key_after_release: data %h want %h", {data_min, data_sec_tens, data_sec_ones}, {m_min, m_tens, m_ones});
            else passed++;
    endtask

    initial begin
        test_reset();
        test_start_idle();
        test_load_and_done();
        test_shift();
        test_err();
        test_pause();
        test_zero_and_start();
        test_reset_mid_run();
        tick(); tick();
        checks++; if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d loads never seen", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
